// File: rtl/fir_dec_pkg.sv
// rtl/fir_dec_pkg.sv - shared constants and helpers for the FIR output decimator
//
// Purpose: default maximum decimation exponent, accumulator width helper and
//          the decimation exponent clamp used by fir_out_decimator.
// Ports:   none (package).

package fir_dec_pkg;

  // Default maximum decimation exponent (D_max = 16).
  localparam int DEC_LOG2_MAX_DEFAULT = 4;

  // Accumulator width: a sum of 2^dmax samples of width dw needs dmax extra bits.
  function automatic int acc_width(input int dw, input int dmax);
    return dw + dmax;
  endfunction

  // Exponents above the configured maximum saturate to the maximum.
  function automatic logic [2:0] clamp_k(input logic [2:0] k, input int kmax);
    if (int'(k) > kmax) begin
      return 3'(kmax);
    end
    return k;
  endfunction

endpackage

// File: rtl/fir_dec_fifo.sv
// rtl/fir_dec_fifo.sv - first-word-fall-through FIFO with occupancy output
//
// Purpose: buffers decimated samples; the head word is visible on head while
//          empty is low, and is removed by pop.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   push, push_data write strobe and word (ignored while full)
//   pop             remove head word (ignored while empty)
//   head            current head word (don't-care while empty)
//   level           number of stored words, 0..DEPTH
//   full, empty     occupancy flags

module fir_dec_fifo #(
  parameter int DW    = 18,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; contents are only observed while non-empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/fir_out_decimator.sv
// rtl/fir_out_decimator.sv - accumulate-and-dump decimator behind the symmetric FIR
//
// Purpose: averages groups of 2^k accepted filter samples and queues the
//          results in an FWFT FIFO. Back-pressures the filter through
//          fir_clk_ena so no sample is lost.
// Build option: FIR_DEC_ROUND_EN - round half up instead of truncating.
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   enable        run enable; low freezes filter and accumulator
//   dec_log2      decimation exponent k (clamped to DEC_LOG2_MAX)
//   s_valid       filter o_valid
//   s_data        filter o_out (signed)
//   fir_clk_ena   filter clk_ena, also the sample-side ready
//   m_valid       FIFO head valid
//   m_data        FIFO head (decimated sample)
//   m_ready       downstream accept
//   level         FIFO occupancy

module fir_out_decimator
  import fir_dec_pkg::*;
#(
  parameter int DW           = 18,
  parameter int DEPTH        = 8,
  parameter int DEC_LOG2_MAX = DEC_LOG2_MAX_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [2:0]             dec_log2,
  input  logic                   s_valid,
  input  logic [DW-1:0]          s_data,
  output logic                   fir_clk_ena,
  output logic                   m_valid,
  output logic [DW-1:0]          m_data,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = acc_width(DW, DEC_LOG2_MAX);
  localparam int PW = DEC_LOG2_MAX + 1;

  logic [PW-1:0]        phase;
  logic [2:0]           k_q;
  logic signed [AW-1:0] acc;

  logic [2:0]           k_cur;
  logic [PW-1:0]        last_phase;
  logic signed [AW-1:0] s_ext;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] sum_adj;
  logic [DW-1:0]        push_data;
  logic                 accept;
  logic                 is_last;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;

  // The exponent is sampled at the first sample of a group; later changes
  // only affect the following group.
  always_comb begin
    k_cur      = (phase == '0) ? clamp_k(dec_log2, DEC_LOG2_MAX) : k_q;
    last_phase = PW'((32'sd1 <<< k_cur) - 32'sd1);
    s_ext      = {{(AW-DW){s_data[DW-1]}}, s_data};
    sum        = (phase == '0) ? s_ext : (acc + s_ext);
`ifdef FIR_DEC_ROUND_EN
    // Half-LSB is below D, so the rounded sum still fits the accumulator.
    if (k_cur == 3'd0) begin
      sum_adj = sum;
    end else begin
      sum_adj = sum + signed'(AW'(1) << (k_cur - 3'd1));
    end
`else
    sum_adj = sum;
`endif
    // Average of D samples always fits DW bits, so plain truncation is safe.
    push_data = DW'(sum_adj >>> k_cur);
  end

  // Filter advances on the same edge a sample is accepted.
  assign fir_clk_ena = enable & ~full & ~reset;
  assign accept      = s_valid & fir_clk_ena;
  assign is_last     = (phase == last_phase);
  assign push        = accept & is_last;
  assign m_valid     = ~empty;
  assign pop         = m_valid & m_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
      acc   <= '0;
      k_q   <= '0;
    end else if (accept) begin
      if (phase == '0) begin
        k_q <= k_cur;
      end
      if (is_last) begin
        phase <= '0;
      end else begin
        acc   <= sum;
        phase <= phase + PW'(1);
      end
    end
  end

  fir_dec_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (m_data),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_fir_out_decimator.sv
// tb/tb_fir_out_decimator.sv - scoreboard bench for fir_out_decimator

module tb_fir_out_decimator;

  localparam int DW    = 18;
  localparam int DEPTH = 4;
  localparam int DMAX  = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [2:0]    dec_log2;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          fir_clk_ena;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic [LW-1:0] level;

  int tests = 0;
  int fails = 0;

  // Reference state: expected FIFO contents and the group being collected.
  logic [DW-1:0] exp_q[$];
  int            mlevel   = 0;
  int            grp_n    = 0;
  longint        grp_sum  = 0;
  int            gk       = 0;
  bit            pop_now;
  bit            acc_now;

  fir_out_decimator #(
    .DW           (DW),
    .DEPTH        (DEPTH),
    .DEC_LOG2_MAX (DMAX)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .dec_log2    (dec_log2),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .fir_clk_ena (fir_clk_ena),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_ready     (m_ready),
    .level       (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Average of D samples: floor(sum / D), optionally with half-LSB added.
  function automatic logic [DW-1:0] ref_avg(input longint sum, input int k);
    longint s;
    longint d;
    longint q;
    s = sum;
    d = longint'(1) << k;
`ifdef FIR_DEC_ROUND_EN
    if (k > 0) s = s + d / 2;
`endif
    q = s / d;
    if ((s % d) != 0 && s < 0) q = q - 1;
    return DW'(q);
  endfunction

  // Reference model: decides what the coming edge does from the bench inputs
  // and the model's own occupancy.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mlevel  = 0;
      grp_n   = 0;
      grp_sum = 0;
      exp_q.delete();
    end else begin
      pop_now = (mlevel != 0) && m_ready;
      acc_now = s_valid && enable && (mlevel < DEPTH);
      if (acc_now) begin
        if (grp_n == 0) gk = (int'(dec_log2) > DMAX) ? DMAX : int'(dec_log2);
        grp_sum = grp_sum + longint'($signed(s_data));
        grp_n++;
        if (grp_n == (1 << gk)) begin
          exp_q.push_back(ref_avg(grp_sum, gk));
          mlevel++;
          grp_n   = 0;
          grp_sum = 0;
        end
      end
      if (pop_now) mlevel--;
    end
  end

  // Monitor: compares outputs mid-cycle and retires popped words.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (reset) begin
      chk("rst_level", longint'(level), 0);
      chk("rst_m_valid", longint'(m_valid), 0);
      chk("rst_fir_clk_ena", longint'(fir_clk_ena), 0);
    end else begin
      chk("fir_clk_ena", longint'(fir_clk_ena), longint'(enable && (mlevel < DEPTH)));
      chk("m_valid", longint'(m_valid), longint'(mlevel != 0));
      chk("level", longint'(level), longint'(mlevel));
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pop_unexpected: got word %0d, expected none", $signed(m_data));
        end else begin
          e = exp_q.pop_front();
          chk("m_data", longint'($signed(m_data)), longint'($signed(e)));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      s_valid = 1'b0;
    end
  endtask

  // Present one sample and hold it until it is accepted (bounded).
  task automatic send(input int d, input int k);
    int n;
    @(posedge clk);
    #1;
    s_valid  = 1'b1;
    s_data   = DW'(d);
    dec_log2 = 3'(k);
    n = 0;
    forever begin
      @(negedge clk);
      if (fir_clk_ena) break;
      n++;
      if (n > 50) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: got no accept, expected accept within 50 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic check_head(input string name, input longint exp);
    @(negedge clk);
    chk({name, "_valid"}, longint'(m_valid), 1);
    chk(name, longint'($signed(m_data)), exp);
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b1;
    dec_log2 = 3'd0;
    s_valid  = 1'b0;
    s_data   = '0;
    m_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    // Basic average, k=2.
    send(4, 2); send(8, 2); send(12, 2); send(16, 2);
    check_head("avg_basic", 10);
    idle(2);

    // Rounding versus truncation.
    send(1, 2); send(2, 2); send(2, 2); send(2, 2);
`ifdef FIR_DEC_ROUND_EN
    check_head("avg_k2_sum7", 2);
`else
    check_head("avg_k2_sum7", 1);
`endif
    send(-3, 1); send(-2, 1);
`ifdef FIR_DEC_ROUND_EN
    check_head("avg_k1_neg", -2);
`else
    check_head("avg_k1_neg", -3);
`endif
    idle(2);

    // Back-pressure with k=0 and a stalled sink.
    @(posedge clk);
    #1;
    m_ready  = 1'b0;
    dec_log2 = 3'd0;
    s_valid  = 1'b1;
    s_data   = DW'(7);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("bp_level_full", longint'(level), DEPTH);
    chk("bp_ena_low", longint'(fir_clk_ena), 0);
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    @(negedge clk);
    chk("bp_level_after_pop", longint'(level), DEPTH - 1);
    chk("bp_ena_release", longint'(fir_clk_ena), 1);
    @(negedge clk);
    chk("bp_level_refill", longint'(level), DEPTH);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    idle(6);

    // Exponent change after the first sample of a group.
    send(10, 1); send(20, 2);
    check_head("k_change_close", 15);
    send(1, 2); send(2, 2); send(3, 2); send(6, 2);
    check_head("k_change_next", 3);
    idle(2);

    // Reset mid-group discards the partial sum.
    send(100, 2); send(100, 2);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    send(4, 2); send(4, 2); send(4, 2); send(4, 2);
    check_head("rst_mid_group", 4);
    idle(2);

    // Enable gating with a held sample.
    send(8, 2); send(8, 2);
    @(posedge clk);
    #1;
    enable  = 1'b0;
    s_valid = 1'b1;
    s_data  = DW'(12);
    repeat (5) begin
      @(negedge clk);
      chk("gate_ena_low", longint'(fir_clk_ena), 0);
      chk("gate_level_hold", longint'(level), 0);
    end
    @(posedge clk);
    #1;
    enable = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    send(12, 2);
    check_head("gate_resume", 10);
    idle(2);

    // Randomized traffic.
    repeat (2500) begin
      @(posedge clk);
      #1;
      s_valid = 1'($urandom_range(0, 1));
      s_data  = DW'($urandom);
      enable  = ($urandom_range(0, 9) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 40) == 0) dec_log2 = 3'($urandom_range(0, 7));
    end

    // Drain.
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    enable  = 1'b1;
    m_ready = 1'b1;
    idle(20);
    chk("drain_empty", longint'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
